// File: rtl/spawn_arb_pkg.sv
// rtl/spawn_arb_pkg.sv - shared types, constants and round-robin search for the spawn stream arbiter
package spawn_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEST_W_DEFAULT = 5;
    localparam int RR_REQ_W       = 64;
    localparam int RR_IDX_W       = 6;

    // First set request at or above ptr, wrapping modulo n; n must not exceed RR_REQ_W.
    function automatic int rr_next(input logic [RR_REQ_W-1:0] req,
                                   input logic [RR_IDX_W-1:0] ptr,
                                   input int                  n);
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int i = 0; i < RR_REQ_W; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/spawn_stream_arbiter_rr_arbiter.sv
// rtl/spawn_stream_arbiter_rr_arbiter.sv - combinational rotating-priority selector
module rr_arbiter
    import spawn_arb_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    int win;

    always_comb begin
        win = rr_next(RR_REQ_W'(req), RR_IDX_W'(ptr), N);
    end

    assign idx       = IDX_W'(win);
    assign any_valid = |req;

endmodule

// File: rtl/spawn_stream_arbiter.sv
// rtl/spawn_stream_arbiter.sv - packet-granular round-robin merge of accelerator spawn streams
// SPAWN_ARB_STATS_EN adds the pkt_count forwarded-packet counter port.
module spawn_stream_arbiter
    import spawn_arb_pkg::*;
#(
    parameter int MAX_ACCS = 16,
    parameter int TID_W    = $clog2(MAX_ACCS),
    parameter int DEST_W   = DEST_W_DEFAULT
) (
    input  logic                       aclk,
    input  logic                       ps_rst,
    input  logic [MAX_ACCS-1:0]        acc_tvalid,
    output logic [MAX_ACCS-1:0]        acc_tready,
    input  logic [64*MAX_ACCS-1:0]     acc_tdata,
    input  logic [DEST_W*MAX_ACCS-1:0] acc_tdest,
    input  logic [MAX_ACCS-1:0]        acc_tlast,
    output logic                       spawn_in_tvalid,
    input  logic                       spawn_in_tready,
    output logic [TID_W-1:0]           spawn_in_tid,
    output logic [DEST_W-1:0]          spawn_in_tdest,
    output logic [63:0]                spawn_in_tdata,
    output logic                       spawn_in_tlast
`ifdef SPAWN_ARB_STATS_EN
    ,
    output logic [31:0]                pkt_count
`endif
);

    arb_state_t         state_q, state_d;
    logic [TID_W-1:0]   grant_q, grant_d;
    logic [TID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tvalid_q, tvalid_d;
    logic [TID_W-1:0]   tid_q, tid_d;
    logic [DEST_W-1:0]  tdest_q, tdest_d;
    logic [63:0]        tdata_q, tdata_d;
    logic               tlast_q, tlast_d;

    logic [TID_W-1:0]   arb_idx;
    logic               arb_any;
    logic               slot_free;
    logic               accept;

    rr_arbiter #(
        .N     (MAX_ACCS),
        .IDX_W (TID_W)
    ) u_rr_arbiter (
        .req       (acc_tvalid),
        .ptr       (rr_ptr_q),
        .idx       (arb_idx),
        .any_valid (arb_any)
    );

    // Ready depends only on the output slot, never on acc_tvalid.
    assign slot_free = !tvalid_q || spawn_in_tready;
    assign accept    = (state_q == BUSY) && acc_tvalid[grant_q] && slot_free;

    always_comb begin
        acc_tready = '0;
        if (state_q == BUSY) acc_tready[grant_q] = slot_free;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        tvalid_d = tvalid_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;

        if (tvalid_q && spawn_in_tready) tvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    tvalid_d = 1'b1;
                    tid_d    = grant_q;
                    tdata_d  = acc_tdata[64*int'(grant_q) +: 64];
                    tdest_d  = acc_tdest[DEST_W*int'(grant_q) +: DEST_W];
                    tlast_d  = acc_tlast[grant_q];
                    if (acc_tlast[grant_q]) begin
                        rr_ptr_d = (grant_q == TID_W'(MAX_ACCS-1)) ? '0 : grant_q + TID_W'(1);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (ps_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tid_q    <= '0;
            tdest_q  <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tvalid_q <= tvalid_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign spawn_in_tvalid = tvalid_q;
    assign spawn_in_tid    = tid_q;
    assign spawn_in_tdest  = tdest_q;
    assign spawn_in_tdata  = tdata_q;
    assign spawn_in_tlast  = tlast_q;

`ifdef SPAWN_ARB_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (accept && acc_tlast[grant_q]) pkt_count_d = pkt_count_q + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (ps_rst) pkt_count_q <= '0;
        else        pkt_count_q <= pkt_count_d;
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_spawn_stream_arbiter.sv
// tb/tb_spawn_stream_arbiter.sv - scoreboard bench for spawn_stream_arbiter
module tb_spawn_stream_arbiter;
    import spawn_arb_pkg::*;

    localparam int N  = 16;
    localparam int TW = 4;
    localparam int DW = 5;

    logic              aclk = 1'b0;
    logic              ps_rst = 1'b1;
    logic [N-1:0]      acc_tvalid = '0;
    logic [N-1:0]      acc_tready;
    logic [64*N-1:0]   acc_tdata = '0;
    logic [DW*N-1:0]   acc_tdest = '0;
    logic [N-1:0]      acc_tlast = '0;
    logic              spawn_in_tvalid;
    logic              spawn_in_tready = 1'b1;
    logic [TW-1:0]     spawn_in_tid;
    logic [DW-1:0]     spawn_in_tdest;
    logic [63:0]       spawn_in_tdata;
    logic              spawn_in_tlast;
`ifdef SPAWN_ARB_STATS_EN
    logic [31:0]       pkt_count;
`endif

    spawn_stream_arbiter #(.MAX_ACCS(N), .TID_W(TW), .DEST_W(DW)) dut (
        .aclk            (aclk),
        .ps_rst          (ps_rst),
        .acc_tvalid      (acc_tvalid),
        .acc_tready      (acc_tready),
        .acc_tdata       (acc_tdata),
        .acc_tdest       (acc_tdest),
        .acc_tlast       (acc_tlast),
        .spawn_in_tvalid (spawn_in_tvalid),
        .spawn_in_tready (spawn_in_tready),
        .spawn_in_tid    (spawn_in_tid),
        .spawn_in_tdest  (spawn_in_tdest),
        .spawn_in_tdata  (spawn_in_tdata),
        .spawn_in_tlast  (spawn_in_tlast)
`ifdef SPAWN_ARB_STATS_EN
        ,
        .pkt_count       (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [63:0]   data;
        logic [DW-1:0] dest;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [TW-1:0] tid;
        logic [DW-1:0] dest;
        logic [63:0]   data;
        logic          last;
    } out_t;

    typedef struct {
        int            port;
        int            len;
        logic [63:0]   base;
        logic [TW-1:0] exp_ptr;
    } vec_t;

    beat_t src_q [N][$];
    out_t  exp_q [$];
    logic  rdy_pat [$];

    int    checks = 0;
    int    failures = 0;
    int    ncycle = 0;
    int    first_valid = -1;
    int    idle_gap = 0;
    int    stalls = 0;
    logic  hold_valid = 1'b0;
    logic  sb_en = 1'b1;
    out_t  held;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                acc_tvalid[i]          = 1'b1;
                acc_tdata[64*i +: 64]  = src_q[i][0].data;
                acc_tdest[DW*i +: DW]  = src_q[i][0].dest;
                acc_tlast[i]           = src_q[i][0].last;
            end else begin
                acc_tvalid[i]          = 1'b0;
                acc_tdata[64*i +: 64]  = '0;
                acc_tdest[DW*i +: DW]  = '0;
                acc_tlast[i]           = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int port, input int len, input logic [63:0] base);
        beat_t b;
        out_t  o;
        for (int k = 0; k < len; k++) begin
            b.data = base + 64'(k);
            b.dest = DW'(port + k);
            b.last = (k == len - 1);
            src_q[port].push_back(b);
            o.tid  = TW'(port);
            o.dest = b.dest;
            o.data = b.data;
            o.last = b.last;
            exp_q.push_back(o);
        end
        drive_srcs();
    endtask

    task automatic cycle();
        out_t cur;
        out_t e;
        @(negedge aclk);
        ncycle++;
        cur = {spawn_in_tid, spawn_in_tdest, spawn_in_tdata, spawn_in_tlast};
        if (hold_valid) check("hold_stable", 128'(cur), 128'(held));
        if (spawn_in_tvalid && !spawn_in_tready) begin
            stalls++;
            check("stall_ready", 128'(acc_tready), 128'(0));
        end
        hold_valid = spawn_in_tvalid && !spawn_in_tready && !ps_rst;
        held = cur;
        if (spawn_in_tvalid && first_valid < 0) first_valid = ncycle;
        if (!spawn_in_tvalid && first_valid >= 0 && exp_q.size() > 0) idle_gap++;
        if (sb_en && spawn_in_tvalid && spawn_in_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", cur);
            end else begin
                e = exp_q.pop_front();
                check("beat", 128'(cur), 128'(e));
            end
        end
        for (int i = 0; i < N; i++)
            if (acc_tvalid[i] && acc_tready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        @(posedge aclk);
        #1;
        spawn_in_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        drive_srcs();
    endtask

    function automatic logic busy();
        logic any = 1'b0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) any = 1'b1;
        return any || (exp_q.size() != 0) || spawn_in_tvalid;
    endfunction

    task automatic run_drain(input string name, input int max);
        int n = 0;
        while (busy() && n < max) begin
            cycle();
            n++;
        end
        if (busy()) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=drained", name);
        end
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        ps_rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive_srcs();
        repeat (2) cycle();
        ps_rst = 1'b0;
        sb_en = 1'b1;
        hold_valid = 1'b0;
    endtask

    initial begin
        vec_t       vecs [4];
        int         load_cyc;
        int         n;
        logic [6:0] pv;

        vecs[0] = '{port: 6,  len: 1, base: 64'h100, exp_ptr: 4'd7};
        vecs[1] = '{port: 15, len: 2, base: 64'h200, exp_ptr: 4'd0};
        vecs[2] = '{port: 0,  len: 4, base: 64'h300, exp_ptr: 4'd1};
        vecs[3] = '{port: 9,  len: 1, base: 64'h400, exp_ptr: 4'd10};

        do_reset();
        check("rst_tvalid", 128'(spawn_in_tvalid), 128'(0));
        check("rst_acc_tready", 128'(acc_tready), 128'(0));
        check("rst_tid", 128'(spawn_in_tid), 128'(0));
        check("rst_tdest", 128'(spawn_in_tdest), 128'(0));
        check("rst_tdata", 128'(spawn_in_tdata), 128'(0));
        check("rst_tlast", 128'(spawn_in_tlast), 128'(0));
        check("rst_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));
        check("rst_state", 128'(dut.state_q), 128'(IDLE));

        load_cyc = ncycle;
        first_valid = -1;
        load_pkt(3, 3, 64'hA);
        run_drain("single", 40);
        check("single_latency", 128'(first_valid - (load_cyc + 1)), 128'(2));
        check("single_rr_ptr", 128'(dut.rr_ptr_q), 128'(4));

        for (int v = 0; v < 4; v++) begin
            load_pkt(vecs[v].port, vecs[v].len, vecs[v].base);
            run_drain("table", 40);
            check("table_rr_ptr", 128'(dut.rr_ptr_q), 128'(vecs[v].exp_ptr));
        end

        do_reset();
        first_valid = -1;
        idle_gap = 0;
        load_pkt(0, 2, 64'h1000);
        load_pkt(5, 2, 64'h5000);
        load_pkt(15, 2, 64'hF000);
        run_drain("contention", 60);
        check("contention_idle_gap", 128'(idle_gap), 128'(2));
        check("contention_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));

        load_pkt(1, 1, 64'h1111);
        load_pkt(15, 1, 64'hFFFF);
        run_drain("wrap", 40);
        check("wrap_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));

        stalls = 0;
        pv = 7'b1010011;
        for (int k = 0; k < 7; k++) rdy_pat.push_back(pv[k]);
        load_pkt(2, 4, 64'h2000);
        run_drain("backpressure", 60);
        check("backpressure_stalled", 128'(stalls > 0), 128'(1));
        check("backpressure_rr_ptr", 128'(dut.rr_ptr_q), 128'(3));

        load_pkt(7, 4, 64'h7000);
        n = 0;
        while (src_q[7].size() > 2 && n < 40) begin
            cycle();
            n++;
        end
        check("midrst_reached_beat2", 128'(src_q[7].size()), 128'(2));
        sb_en = 1'b0;
        ps_rst = 1'b1;
        src_q[7].delete();
        exp_q.delete();
        drive_srcs();
        cycle();
        ps_rst = 1'b0;
        sb_en = 1'b1;
        hold_valid = 1'b0;
        check("midrst_tvalid", 128'(spawn_in_tvalid), 128'(0));
        check("midrst_acc_tready", 128'(acc_tready), 128'(0));
        check("midrst_state", 128'(dut.state_q), 128'(IDLE));
        check("midrst_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));
        repeat (4) cycle();
        check("midrst_quiet", 128'(spawn_in_tvalid), 128'(0));

`ifdef SPAWN_ARB_STATS_EN
        do_reset();
        load_pkt(0, 1, 64'hC0);
        run_drain("stats", 40);
        load_pkt(1, 3, 64'hC1);
        run_drain("stats", 40);
        load_pkt(0, 2, 64'hC2);
        run_drain("stats", 40);
        load_pkt(1, 1, 64'hC3);
        run_drain("stats", 40);
        load_pkt(0, 2, 64'hC4);
        run_drain("stats", 40);
        check("stats_count", 128'(pkt_count), 128'(5));
        do_reset();
        check("stats_rst", 128'(pkt_count), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spawn_stream_arbiter.md
Name: spawn_stream_arbiter

Overview:
- Merges the per-accelerator task-creation AXI-Stream packets into the single spawn_in stream consumed by the OmpSs manager.
- Round-robin arbitration at packet granularity. A grant holds until the beat with tlast has been accepted.
- Stamps tid with the winning accelerator index.
- Output is a registered slice running at full throughput, one beat per cycle once granted.

Parameters:
- MAX_ACCS, 16, number of accelerator input ports; must be at least 2.
- TID_W, $clog2(MAX_ACCS), width of the tid/index field.
- DEST_W, 5, width of tdest, passed through unchanged.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- ps_rst  in  1  synchronous, active-high reset.
- acc_tvalid  in  MAX_ACCS  per-accelerator valid.
- acc_tready  out  MAX_ACCS  per-accelerator ready.
- acc_tdata  in  64*MAX_ACCS  port i occupies bits [64i+63:64i].
- acc_tdest  in  DEST_W*MAX_ACCS  port i occupies bits [DEST_W*i+DEST_W-1:DEST_W*i].
- acc_tlast  in  MAX_ACCS  per-accelerator last.
- spawn_in_tvalid  out  1  merged output valid.
- spawn_in_tready  in  1  manager ready.
- spawn_in_tid  out  TID_W  index of the source accelerator.
- spawn_in_tdest  out  DEST_W  passthrough of the source tdest.
- spawn_in_tdata  out  64  passthrough of the source tdata.
- spawn_in_tlast  out  1  passthrough of the source tlast.
- pkt_count  out  32  forwarded-packet counter; present only with SPAWN_ARB_STATS_EN.

Behaviour:
- Clock and reset: one clock, aclk. Reset ps_rst is synchronous, active-high.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - acc_tready=0, spawn_in_tvalid=0.
  - spawn_in_tid/tdest/tdata/tlast=0.
  - pkt_count=0.
- Reset mid-packet: the partial packet is dropped with no further beats. The upstream must also be reset.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any acc_tvalid is set, select the first set index searching upward from rr_ptr, wrapping modulo MAX_ACCS.
  - Register it in grant and go to BUSY.
  - All acc_tready stay 0 in IDLE.
- BUSY:
  - acc_tready[grant] = !spawn_in_tvalid || spawn_in_tready. All other readies are 0.
  - This ready is combinational from the output-register state and spawn_in_tready; there is no combinational path from acc_tvalid.
- Beat accept (acc_tvalid[grant] && acc_tready[grant]):
  - Load the output register with tdata, tdest, tlast of port grant.
  - Set spawn_in_tid=grant and spawn_in_tvalid=1.
- Output drain: spawn_in_tvalid clears when spawn_in_tready=1 and no new beat is accepted that cycle.
- Packet end: on accepting a beat with tlast=1, set rr_ptr = grant+1 (wrapping MAX_ACCS-1 to 0) and return to IDLE.
- Arbitration cost: exactly one dead cycle per packet.
- Latency: acc_tvalid rising in IDLE at cycle t gives grant at t+1, first beat accepted at t+1, spawn_in_tvalid=1 at t+2.
- Stability: while spawn_in_tvalid=1 and spawn_in_tready=0, all spawn_in_* outputs hold stable.
- Granted port drops valid mid-packet: grant is held; no other port is served until tlast.
- Single-beat packets (tlast on the first beat) are legal.
- Simultaneous requests: exactly one port wins, by the rotating priority. Each requesting port is served once before any port repeats.
- Ports with acc_tvalid=0 at arbitration time are skipped.

Optional Feature:
- Macro: SPAWN_ARB_STATS_EN.
- Defined:
  - pkt_count increments by 1 on each accepted beat with tlast=1.
  - Wraps 2^32-1 to 0.
  - Reset to 0.
- Undefined: the pkt_count port and its counter are absent; no other behaviour changes.

Decomposition:
- Shared package spawn_arb_pkg:
  - typedef arb_state_t {IDLE, BUSY}.
  - Constant DEST_W_DEFAULT=5.
  - Function rr_next(req, ptr) returning the winning index.
- One natural sub-module, rr_arbiter: a combinational round-robin priority selector (request vector plus pointer in, index and any_valid out). The FSM and output register stay in the top.

Test Plan:
- Single packet: port 3 sends 3 beats 0xA,0xB,0xC (tlast on 0xC), spawn_in_tready=1 -> output beats 0xA,0xB,0xC with tid=3, tlast only on 0xC, first valid 2 cycles after acc_tvalid; then rr_ptr=4.
- Contention: ports 0, 5 and 15 each hold a 2-beat packet from reset -> output order tid 0, then 5, then 15, with no interleaving; one idle cycle between packets.
- Backpressure: spawn_in_tready toggles 1,0,0,1 during a 4-beat packet from port 2 -> no beat lost or duplicated; outputs stable while tready=0; acc_tready[2]=0 while the output is full and stalled.
- Wrap-around: after port 15 is served, ports 15 and 1 both request -> port 1 wins.
- Reset mid-packet: ps_rst=1 for 1 cycle after beat 2 of 4 from port 7 -> next cycle spawn_in_tvalid=0, all acc_tready=0, state=IDLE, rr_ptr=0.
- Stats (macro defined): 5 packets of mixed length from ports 0 and 1 -> pkt_count=5; after ps_rst, pkt_count=0.
